// File: rtl/axi_lite_led_responder_pkg.sv
// Shared definitions for the AXI4-Lite LED responder: register word offsets,
// response codes and the write/read channel state encodings.
package axi_lite_led_responder_pkg;

    // Word offsets, i.e. address bits [3:2]
    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_LED   = 2'd1;
    localparam logic [1:0] REG_TICKS = 2'd2;
    localparam logic [1:0] REG_ID    = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) result[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_lite_led_responder.sv
// AXI4-Lite slave exposing a DATA word, a 4-bit LED register, a free-running
// cycle counter and a read-only ID word; read and write paths are independent.
module axi_lite_led_responder
    import axi_lite_led_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter logic [31:0] ID_VALUE   = 32'h4C454431
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iAWVALID,
    output logic                  oAWREADY,
    input  logic [ADDR_WIDTH-1:0] iAWADDR,
    input  logic                  iWVALID,
    output logic                  oWREADY,
    input  logic [31:0]           iWDATA,
    input  logic [3:0]            iWSTRB,
    output logic                  oBVALID,
    input  logic                  iBREADY,
    output logic [1:0]            oBRESP,
    input  logic                  iARVALID,
    output logic                  oARREADY,
    input  logic [ADDR_WIDTH-1:0] iARADDR,
    output logic                  oRVALID,
    input  logic                  iRREADY,
    output logic [31:0]           oRDATA,
    output logic [1:0]            oRRESP,
    output logic [31:0]           oData,
    output logic [3:0]            oLed
);

    // Holds the READYs low until the first edge after reset release
    logic        r_init;
    wr_state_e   r_wstate;
    rd_state_e   r_rstate;
    logic [1:0]  r_awword;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [31:0] r_data;
    logic [3:0]  r_led;
    logic [31:0] r_ticks;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_wr_fire;
    logic [1:0]  w_wr_word;
    logic [31:0] w_wr_wdata;
    logic [3:0]  w_wr_strb;
    logic        w_wr_ok;
    logic [31:0] w_rd_value;
    logic        w_unused;

    // Byte-offset bits and any address bits above the map are don't-care
    assign w_unused = ^{iAWADDR, iARADDR};

    assign oAWREADY = r_init && (r_wstate == W_IDLE || r_wstate == W_HAVE_DATA);
    assign oWREADY  = r_init && (r_wstate == W_IDLE || r_wstate == W_HAVE_ADDR);
    assign oARREADY = r_init && (r_rstate == R_IDLE);
    assign oBVALID  = r_bvalid;
    assign oBRESP   = r_bresp;
    assign oRVALID  = r_rvalid;
    assign oRDATA   = r_rdata;
    assign oRRESP   = r_rresp;
    assign oData    = r_data;
    assign oLed     = r_led;

    assign w_aw_hs = iAWVALID && oAWREADY;
    assign w_w_hs  = iWVALID && oWREADY;
    assign w_ar_hs = iARVALID && oARREADY;

    // Merge the captured half of the write with the half arriving now
    always_comb begin
        w_wr_fire  = 1'b0;
        w_wr_word  = r_awword;
        w_wr_wdata = r_wdata;
        w_wr_strb  = r_wstrb;
        case (r_wstate)
            W_IDLE: begin
                w_wr_fire  = w_aw_hs && w_w_hs;
                w_wr_word  = iAWADDR[3:2];
                w_wr_wdata = iWDATA;
                w_wr_strb  = iWSTRB;
            end
            W_HAVE_ADDR: begin
                w_wr_fire  = w_w_hs;
                w_wr_wdata = iWDATA;
                w_wr_strb  = iWSTRB;
            end
            W_HAVE_DATA: begin
                w_wr_fire = w_aw_hs;
                w_wr_word = iAWADDR[3:2];
            end
            default: ;
        endcase
    end

    assign w_wr_ok = (w_wr_word == REG_DATA) || (w_wr_word == REG_LED);

    always_comb begin
        w_rd_value = 32'd0;
        case (iARADDR[3:2])
            REG_DATA:  w_rd_value = r_data;
            REG_LED:   w_rd_value = {28'd0, r_led};
            REG_TICKS: w_rd_value = r_ticks;
            REG_ID:    w_rd_value = ID_VALUE;
            default:   w_rd_value = 32'd0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_init <= 1'b0;
        end else begin
            r_init <= 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_wstate <= W_IDLE;
            r_awword <= 2'd0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_wr_fire) begin
                        r_wstate <= W_RESP;
                    end else if (w_aw_hs) begin
                        r_awword <= iAWADDR[3:2];
                        r_wstate <= W_HAVE_ADDR;
                    end else if (w_w_hs) begin
                        r_wdata  <= iWDATA;
                        r_wstrb  <= iWSTRB;
                        r_wstate <= W_HAVE_DATA;
                    end
                end
                W_HAVE_ADDR, W_HAVE_DATA: begin
                    if (w_wr_fire) r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (iBREADY) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_data  <= 32'd0;
            r_led   <= 4'd0;
            r_ticks <= 32'd0;
        end else begin
            r_ticks <= r_ticks + 32'd1;
            if (w_wr_fire && w_wr_word == REG_DATA) begin
                r_data <= apply_strb(r_data, w_wr_wdata, w_wr_strb);
            end
            if (w_wr_fire && w_wr_word == REG_LED && w_wr_strb[0]) begin
                r_led <= w_wr_wdata[3:0];
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata  <= w_rd_value;
                        r_rresp  <= RESP_OKAY;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (iRREADY) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_led_responder.sv
// Scoreboard bench for axi_lite_led_responder: expected B/R responses are queued at
// issue and checked by a monitor as the DUT hands them over.
module tb_axi_lite_led_responder;

    localparam logic [31:0] ID_WORD = 32'h4C454431;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    logic        Clock;
    logic        Reset;
    logic        iAWVALID;
    logic        oAWREADY;
    logic [3:0]  iAWADDR;
    logic        iWVALID;
    logic        oWREADY;
    logic [31:0] iWDATA;
    logic [3:0]  iWSTRB;
    logic        oBVALID;
    logic        iBREADY;
    logic [1:0]  oBRESP;
    logic        iARVALID;
    logic        oARREADY;
    logic [3:0]  iARADDR;
    logic        oRVALID;
    logic        iRREADY;
    logic [31:0] oRDATA;
    logic [1:0]  oRRESP;
    logic [31:0] oData;
    logic [3:0]  oLed;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [1:0]  bq[$];
    logic [31:0] rq[$];
    logic [31:0] m_data;
    logic [3:0]  m_led;
    logic [31:0] tb_ticks;
    logic [31:0] r_last;

    axi_lite_led_responder #(
        .ADDR_WIDTH (4),
        .ID_VALUE   (ID_WORD)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .iAWVALID (iAWVALID),
        .oAWREADY (oAWREADY),
        .iAWADDR  (iAWADDR),
        .iWVALID  (iWVALID),
        .oWREADY  (oWREADY),
        .iWDATA   (iWDATA),
        .iWSTRB   (iWSTRB),
        .oBVALID  (oBVALID),
        .iBREADY  (iBREADY),
        .oBRESP   (oBRESP),
        .iARVALID (iARVALID),
        .oARREADY (oARREADY),
        .iARADDR  (iARADDR),
        .oRVALID  (oRVALID),
        .iRREADY  (iRREADY),
        .oRDATA   (oRDATA),
        .oRRESP   (oRRESP),
        .oData    (oData),
        .oLed     (oLed)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference cycle counter: cleared by reset, +1 on every edge afterwards
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) tb_ticks <= 32'd0;
        else        tb_ticks <= tb_ticks + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        if (s[0]) r[7:0]   = n[7:0];
        if (s[1]) r[15:8]  = n[15:8];
        if (s[2]) r[23:16] = n[23:16];
        if (s[3]) r[31:24] = n[31:24];
        return r;
    endfunction

    // Response monitor: pops the scoreboard whenever a B or R handshake is about to occur
    always @(negedge Clock) begin
        if (Reset && oBVALID && iBREADY) begin
            if (bq.size() == 0) check("b_unexpected", 32'(oBVALID), 32'd0);
            else                check("bresp", 32'(oBRESP), 32'(bq.pop_front()));
        end
        if (Reset && oRVALID && iRREADY) begin
            r_last = oRDATA;
            check("rresp", 32'(oRRESP), 32'(OKAY));
            if (rq.size() == 0) check("r_unexpected", 32'(oRVALID), 32'd0);
            else                check("rdata", oRDATA, rq.pop_front());
        end
    end

    // Returns at the negedge before the edge on which the selected READYs handshake
    task automatic wait_ready(input logic aw, input logic w, input logic ar, input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge Clock);
            if ((!aw || oAWREADY) && (!w || oWREADY) && (!ar || oARREADY)) break;
            n++;
            if (n > 64) begin
                n_bad++;
                $display("FAIL %s: READY timeout got 0 expected 1", tag);
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
                $fatal(1, "handshake timeout");
            end
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // w_lead: 0 = AW and W together, >0 = W that many cycles before AW, <0 = AW first
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input int hold);
        logic [1:0] exp;
        exp = (addr[3:2] < 2'd2) ? OKAY : SLVERR;
        bq.push_back(exp);
        iAWADDR = addr;
        iWDATA  = data;
        iWSTRB  = strb;
        if (w_lead == 0) begin
            iAWVALID = 1'b1;
            iWVALID  = 1'b1;
            wait_ready(1'b1, 1'b1, 1'b0, "aw_w");
            tick();
            iAWVALID = 1'b0;
            iWVALID  = 1'b0;
        end else if (w_lead > 0) begin
            iWVALID = 1'b1;
            wait_ready(1'b0, 1'b1, 1'b0, "w_first");
            tick();
            iWVALID = 1'b0;
            check("wready_after_w", 32'(oWREADY), 32'd0);
            check("awready_after_w", 32'(oAWREADY), 32'd1);
            repeat (w_lead - 1) tick();
            iAWVALID = 1'b1;
            wait_ready(1'b1, 1'b0, 1'b0, "aw_second");
            tick();
            iAWVALID = 1'b0;
        end else begin
            iAWVALID = 1'b1;
            wait_ready(1'b1, 1'b0, 1'b0, "aw_first");
            tick();
            iAWVALID = 1'b0;
            check("awready_after_aw", 32'(oAWREADY), 32'd0);
            check("wready_after_aw", 32'(oWREADY), 32'd1);
            repeat (-w_lead - 1) tick();
            iWVALID = 1'b1;
            wait_ready(1'b0, 1'b1, 1'b0, "w_second");
            tick();
            iWVALID = 1'b0;
        end
        if (addr[3:2] == 2'd0) m_data = merge(m_data, data, strb);
        if (addr[3:2] == 2'd1 && strb[0]) m_led = data[3:0];
        check("bvalid", 32'(oBVALID), 32'd1);
        check("odata", oData, m_data);
        check("oled", 32'(oLed), 32'(m_led));
        for (int i = 0; i < hold; i++) begin
            check("bvalid_hold", 32'(oBVALID), 32'd1);
            check("bresp_hold", 32'(oBRESP), 32'(exp));
            tick();
        end
        iBREADY = 1'b1;
        tick();
        iBREADY = 1'b0;
        check("bvalid_clr", 32'(oBVALID), 32'd0);
        check("awready_back", 32'(oAWREADY), 32'd1);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int hold, output logic [31:0] exp);
        iARADDR  = addr;
        iARVALID = 1'b1;
        wait_ready(1'b0, 1'b0, 1'b1, "ar");
        case (addr[3:2])
            2'd0:    exp = m_data;
            2'd1:    exp = {28'd0, m_led};
            2'd2:    exp = tb_ticks;
            default: exp = ID_WORD;
        endcase
        rq.push_back(exp);
        tick();
        iARVALID = 1'b0;
        check("rvalid", 32'(oRVALID), 32'd1);
        check("arready_busy", 32'(oARREADY), 32'd0);
        for (int i = 0; i < hold; i++) begin
            check("rdata_hold", oRDATA, exp);
            check("rvalid_hold", 32'(oRVALID), 32'd1);
            tick();
        end
        iRREADY = 1'b1;
        tick();
        iRREADY = 1'b0;
        check("rvalid_clr", 32'(oRVALID), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] v1;
        logic [31:0] t1;
        Reset    = 1'b0;
        iAWVALID = 1'b0;
        iAWADDR  = 4'd0;
        iWVALID  = 1'b0;
        iWDATA   = 32'd0;
        iWSTRB   = 4'd0;
        iBREADY  = 1'b0;
        iARVALID = 1'b0;
        iARADDR  = 4'd0;
        iRREADY  = 1'b0;
        m_data   = 32'd0;
        m_led    = 4'd0;
        r_last   = 32'd0;

        repeat (3) tick();
        check("rst_awready", 32'(oAWREADY), 32'd0);
        check("rst_wready", 32'(oWREADY), 32'd0);
        check("rst_arready", 32'(oARREADY), 32'd0);
        check("rst_bvalid", 32'(oBVALID), 32'd0);
        check("rst_rvalid", 32'(oRVALID), 32'd0);
        check("rst_bresp", 32'(oBRESP), 32'd0);
        check("rst_rresp", 32'(oRRESP), 32'd0);
        check("rst_rdata", oRDATA, 32'd0);
        check("rst_data", oData, 32'd0);
        check("rst_led", 32'(oLed), 32'd0);
        #2 Reset = 1'b1;
        #1 check("ready_before_edge", 32'(oAWREADY), 32'd0);
        tick();
        check("awready_after_rel", 32'(oAWREADY), 32'd1);
        check("wready_after_rel", 32'(oWREADY), 32'd1);
        check("arready_after_rel", 32'(oARREADY), 32'd1);

        axi_write(4'h0, 32'hDEADBEEF, 4'hF, 0, 0);
        axi_write(4'h4, 32'h000000FA, 4'hF, 3, 0);
        check("led_fa", 32'(oLed), 32'hA);
        axi_read(4'h4, 0, v);
        axi_write(4'h0, 32'h11223344, 4'hF, -2, 0);
        axi_write(4'h0, 32'hAABBCCDD, 4'b0101, 0, 0);
        check("strb_merge", oData, 32'h11BB33DD);
        axi_write(4'h0, 32'hFFFFFFFF, 4'h0, 1, 0);
        check("strb_zero", oData, 32'h11BB33DD);

        axi_write(4'h8, 32'h00000000, 4'hF, 0, 5);
        axi_write(4'hC, 32'h12345678, 4'hF, -1, 0);
        axi_read(4'h8, 0, v);
        axi_read(4'hC, 5, v);
        axi_read(4'h7, 0, v);
        axi_read(4'h1, 2, v);

        // Same-edge write and read of DATA: the read must see the old value
        fork
            axi_write(4'h0, 32'hCAFEF00D, 4'hF, 0, 0);
            axi_read(4'h0, 0, v);
        join
        check("same_edge_new", oData, 32'hCAFEF00D);

        axi_read(4'h8, 0, t1);
        v1 = r_last;
        for (int i = 0; i < 40 && tb_ticks != t1 + 32'd10; i++) tick();
        axi_read(4'h8, 0, v);
        check("tick_delta", r_last - v1, 32'd10);

        // Reset between AW and W: the captured address must be discarded
        iAWADDR  = 4'h0;
        iAWVALID = 1'b1;
        wait_ready(1'b1, 1'b0, 1'b0, "aw_pre_reset");
        tick();
        iAWVALID = 1'b0;
        #2 Reset = 1'b0;
        m_data = 32'd0;
        m_led  = 4'd0;
        #1;
        check("midrst_awready", 32'(oAWREADY), 32'd0);
        check("midrst_bvalid", 32'(oBVALID), 32'd0);
        check("midrst_data", oData, 32'd0);
        repeat (2) tick();
        #3 Reset = 1'b1;
        tick();
        iWDATA  = 32'h12345678;
        iWSTRB  = 4'hF;
        iWVALID = 1'b1;
        wait_ready(1'b0, 1'b1, 1'b0, "w_post_reset");
        tick();
        iWVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("no_stale_bvalid", 32'(oBVALID), 32'd0);
            check("no_stale_data", oData, 32'd0);
            tick();
        end
        bq.push_back(OKAY);
        iAWADDR  = 4'h0;
        iAWVALID = 1'b1;
        wait_ready(1'b1, 1'b0, 1'b0, "aw_post_reset");
        tick();
        iAWVALID = 1'b0;
        m_data = 32'h12345678;
        check("post_rst_bvalid", 32'(oBVALID), 32'd1);
        check("post_rst_data", oData, m_data);
        iBREADY = 1'b1;
        tick();
        iBREADY = 1'b0;

        repeat (2) tick();
        check("bq_drained", 32'(bq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
